// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared types: function codes, FSM state encoding and
// the boundary above which function codes are treated as illegal.
package alu_arb_pkg;

    typedef enum logic [2:0] {
        ADD     = 3'd0,
        OR_RED  = 3'd1,
        AND_RED = 3'd2,
        CONCAT  = 3'd3
    } func_e;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_RESP = 2'd2;

    localparam logic [2:0] ILLEGAL_MIN = 3'd4;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first set request
// at or after ptr, wrapping. Ports: req, ptr in; gnt (one-hot), idx, any out.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin shared ALU with IDLE/EXEC/RESP handshake.
// Ports: clk, reset_n, req_valid/ready/a/b/func (per requester),
// rsp_valid/ready/id/data, rsp_err (only with ALU_ARB_ILLEGAL_EN).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_func,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [2*N-1:0]    rsp_data
`ifdef ALU_ARB_ILLEGAL_EN
    ,
    output logic              rsp_err
`endif
);

    state_t          state, nstate;
    logic [IW-1:0]   rr_ptr;
    logic [N-1:0]    cap_a, cap_b;
    logic [2:0]      cap_func;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            gany;
    logic            accept;

    function automatic logic [2*N-1:0] alu_fn(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [2:0]   f
    );
        logic [2*N-1:0] r;
        r = '0;
        if (f < ILLEGAL_MIN) begin
            case (func_e'(f))
                ADD:     r = {{N{1'b0}}, a} + {{N{1'b0}}, b};
                OR_RED:  r[0] = |{a, b};
                AND_RED: r[0] = &{a, b};
                CONCAT:  r = {a, b};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    assign accept = (state == S_IDLE) && gany;

    // Gated by reset_n so no grant is offered while reset is held.
    assign req_ready = (reset_n && accept) ? gnt : '0;
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (gany) nstate = S_EXEC;
            S_EXEC:  nstate = S_RESP;
            S_RESP:  if (rsp_ready) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // rsp_id doubles as the captured grant id; it is stable from accept
    // until the response handshake completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            cap_a    <= '0;
            cap_b    <= '0;
            cap_func <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                cap_a    <= req_a[int'(gidx)*N +: N];
                cap_b    <= req_b[int'(gidx)*N +: N];
                cap_func <= req_func[int'(gidx)*3 +: 3];
                rsp_id   <= gidx;
            end
            if (state == S_EXEC)
                rsp_data <= alu_fn(cap_a, cap_b, cap_func);
            if (state == S_RESP && rsp_ready)
                rr_ptr <= (int'(rsp_id) == NREQ - 1) ? '0 : rsp_id + 1'b1;
        end
    end

`ifdef ALU_ARB_ILLEGAL_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rsp_err <= 1'b0;
        else if (state == S_EXEC)
            rsp_err <= (cap_func >= ILLEGAL_MIN);
    end
`else
    // Codes at or above ILLEGAL_MIN simply yield a zero result in alu_fn.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter (N=4, NREQ=4).
// Reference model tracks grant/response timing at transaction level.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [11:0] req_func = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
`ifdef ALU_ARB_ILLEGAL_EN
    logic        rsp_err;
`endif

    alu_arbiter #(.N(N), .NREQ(NR)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_func  (req_func),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef ALU_ARB_ILLEGAL_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int       id;
        int       data;
        bit       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bit   m_busy = 0;
    int   m_age  = 0;
    int   m_ptr  = 0;
    int   m_gid  = 0;
    logic [3:0] obs_rr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_res(input int a, input int b, input int f);
        case (f)
            0: return a + b;
            1: return ((a != 0) || (b != 0)) ? 1 : 0;
            2: return ((a == 15) && (b == 15)) ? 1 : 0;
            3: return a * 16 + b;
            default: return 0;
        endcase
    endfunction

    task automatic cyc(input logic [3:0] v, input logic [15:0] a,
                       input logic [15:0] b, input logic [11:0] f,
                       input logic rdy);
        int g;
        int e;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_func  = f;
        rsp_ready = rdy;
        #1;
        chk("rsp_valid", int'(rsp_valid), (m_busy && m_age >= 1) ? 1 : 0);
        g = -1;
        if (!m_busy)
            for (int k = 0; k < NR; k++)
                if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        e = (g >= 0) ? (1 << g) : 0;
        obs_rr = req_ready;
        chk("req_ready", int'(req_ready), e);
        if (g >= 0) begin
            sb.push_back('{g,
                ref_res(int'(a[g*4 +: 4]), int'(b[g*4 +: 4]), int'(f[g*3 +: 3])),
                int'(f[g*3 +: 3]) >= 4});
            m_busy = 1;
            m_age  = 0;
            m_gid  = g;
        end else if (m_busy) begin
            if (m_age >= 1 && rdy) begin
                m_busy = 0;
                m_ptr  = (m_gid + 1) % NR;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && m_busy; i++) cyc(4'h0, '0, '0, '0, 1'b1);
        chk("drain", int'(m_busy), 0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    chk("rsp_id", int'(rsp_id), sb[0].id);
                    chk("rsp_data", int'(rsp_data), sb[0].data);
`ifdef ALU_ARB_ILLEGAL_EN
                    chk("rsp_err", int'(rsp_err), int'(sb[0].err));
`endif
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int gid[$];
        int gcyc[$];
        #2;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(4'hF, 16'($urandom), 16'($urandom), 12'($urandom), 1'b1);
            for (int k = 0; k < NR; k++)
                if (obs_rr[k]) begin
                    gid.push_back(k);
                    gcyc.push_back(i);
                end
        end
        chk("fair_count", gid.size(), 5);
        for (int i = 0; i < 5 && i < gid.size(); i++) begin
            chk("fair_id", gid[i], i % NR);
            if (i > 0) chk("fair_gap", gcyc[i] - gcyc[i-1], 3);
        end
        drain();

        cyc(4'h1, 16'h000F, 16'h0001, 12'h000, 1'b1);
        drain();

        cyc(4'h1, 16'h000A, 16'h0005, 12'h003, 1'b0);
        for (int i = 0; i < 6; i++) cyc(4'hF, 16'($urandom), 16'($urandom), '0, 1'b0);
        cyc(4'h0, '0, '0, '0, 1'b1);
        drain();

        cyc(4'h4, 16'h0000, 16'h0000, 12'h040, 1'b1);
        drain();
        cyc(4'h2, 16'h00F0, 16'h00F0, 12'h010, 1'b1);
        drain();
        cyc(4'h8, 16'hF000, 16'hE000, 12'h400, 1'b1);
        drain();
        cyc(4'h1, 16'h0007, 16'h0003, 12'h006, 1'b1);
        drain();

        cyc(4'h1, 16'h0003, 16'h0004, 12'h000, 1'b0);
        cyc(4'h0, '0, '0, '0, 1'b0);
        cyc(4'h0, '0, '0, '0, 1'b0);
        #2;
        reset_n   = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rsp_data", int'(rsp_data), 0);
        chk("mid_rst_rsp_id", int'(rsp_id), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        req_valid = 4'h0;
        sb.delete();
        m_busy = 0;
        m_ptr  = 0;
        @(negedge clk);
        reset_n = 1'b1;
        cyc(4'hE, 16'h0210, 16'h0120, 12'h000, 1'b1);
        chk("post_rst_grant", int'(obs_rr), 2);
        drain();

        for (int i = 0; i < 400; i++)
            cyc(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                12'($urandom), ($urandom_range(0, 3) != 0));
        drain();
        cyc(4'h0, '0, '0, '0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
